// File: rtl/aes_key_ctrl_pkg.sv
// rtl/aes_key_ctrl_pkg.sv - shared constants, state encoding and strobe bundle for the AES key schedule controller
package aes_key_ctrl_pkg;
    localparam int NR_128       = 10;
    localparam int NR_256       = 13;
    localparam int BEAT_W       = 2;
    localparam int ROUND_W      = 4;
    localparam int SBOX_LAT_DEF = 4;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_OUT   = 3'd2;
    localparam state_t ST_ISSUE = 3'd3;
    localparam state_t ST_WAIT  = 3'd4;
    localparam state_t ST_UPD   = 3'd5;
    localparam state_t ST_DONE  = 3'd6;

    typedef struct packed {
        logic key_ready;
        logic ak_valid;
        logic done;
        logic init;
        logic loop;
        logic add_from_sb;
        logic enable_pipe_low;
        logic enable_pipe_high;
        logic feedback_from_high;
        logic disable_rot_rcon;
        logic col7_toSB;
        logic rcon_rst;
        logic rcon_update;
        logic rcon_mode_256;
        logic enable_buffer_from_sbox;
        logic rst_buffer_from_sbox;
        logic sbox_key_valid;
    } ctrl_t;
endpackage

// File: rtl/aes_key_ctrl_cnt.sv
// rtl/aes_key_ctrl_cnt.sv - beat, Sbox-wait and round counters with terminal-count flags
module aes_key_ctrl_cnt
    import aes_key_ctrl_pkg::*;
#(
    parameter int SBOX_LAT = SBOX_LAT_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               beat_clr_i,
    input  logic               beat_inc_i,
    input  logic               wait_clr_i,
    input  logic               wait_inc_i,
    input  logic               round_clr_i,
    input  logic               round_inc_i,
    output logic [BEAT_W-1:0]  beat_o,
    output logic               beat_last_o,
    output logic               wait_last_o,
    output logic [ROUND_W-1:0] round_o
);
    // The wait phase lasts SBOX_LAT-1 cycles, so the counter terminates at SBOX_LAT-2.
    localparam int WAIT_W = (SBOX_LAT > 2) ? $clog2(SBOX_LAT - 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_TC = WAIT_W'((SBOX_LAT > 1) ? SBOX_LAT - 2 : 0);

    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [ROUND_W-1:0] round_q, round_d;

    always_comb begin
        beat_d  = beat_q;
        wait_d  = wait_q;
        round_d = round_q;
        if (beat_clr_i) begin
            beat_d = '0;
        end else if (beat_inc_i) begin
            beat_d = beat_q + 1'b1;
        end
        if (wait_clr_i) begin
            wait_d = '0;
        end else if (wait_inc_i) begin
            wait_d = wait_q + 1'b1;
        end
        if (round_clr_i) begin
            round_d = '0;
        end else if (round_inc_i && (round_q != '1)) begin
            round_d = round_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_q  <= '0;
            wait_q  <= '0;
            round_q <= '0;
        end else begin
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            round_q <= round_d;
        end
    end

    assign beat_o      = beat_q;
    assign beat_last_o = (beat_q == '1);
    assign wait_last_o = (wait_q == WAIT_TC);
    assign round_o     = round_q;
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - key datapath sequencing controller; AES256_EN enables the AES-256 schedule
module aes_key_sched_ctrl
    import aes_key_ctrl_pkg::*;
#(
    parameter int SBOX_LAT = SBOX_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_valid,
    output logic key_ready,
    input  logic mode_256,
    output logic ak_valid,
    input  logic ak_ready,
    output logic done,
    output logic init,
    output logic loop,
    output logic add_from_sb,
    output logic enable_pipe_low,
    output logic enable_pipe_high,
    output logic feedback_from_high,
    output logic disable_rot_rcon,
    output logic col7_toSB,
    output logic rcon_rst,
    output logic rcon_update,
    output logic rcon_mode_256,
    output logic enable_buffer_from_sbox,
    output logic rst_buffer_from_sbox,
    output logic sbox_key_valid
);
    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic               half_q, half_d;
    logic               beat_clr, beat_inc, wait_clr, wait_inc, round_clr, round_inc;
    logic [BEAT_W-1:0]  beat;
    logic               beat_last, wait_last;
    logic [ROUND_W-1:0] round;
    logic [ROUND_W-1:0] n_upd;
    logic               upd_half;
    ctrl_t              c, c_out;

    aes_key_ctrl_cnt #(.SBOX_LAT(SBOX_LAT)) u_cnt (
        .clk_i       (clk),
        .rst_i       (rst),
        .beat_clr_i  (beat_clr),
        .beat_inc_i  (beat_inc),
        .wait_clr_i  (wait_clr),
        .wait_inc_i  (wait_inc),
        .round_clr_i (round_clr),
        .round_inc_i (round_inc),
        .beat_o      (beat),
        .beat_last_o (beat_last),
        .wait_last_o (wait_last),
        .round_o     (round)
    );

    assign n_upd    = mode_q ? ROUND_W'(NR_256) : ROUND_W'(NR_128);
    // AES-256 updates alternate halves: odd updates refresh the low half, even ones the high half.
    assign upd_half = mode_q & round[0];

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        half_d    = half_q;
        beat_clr  = 1'b0;
        beat_inc  = 1'b0;
        wait_clr  = 1'b0;
        wait_inc  = 1'b0;
        round_clr = 1'b0;
        round_inc = 1'b0;
        c         = '0;
        case (state_q)
            ST_IDLE: begin
                c.key_ready = 1'b1;
                if (key_valid) begin
                    state_d = ST_LOAD;
`ifdef AES256_EN
                    mode_d = mode_256;
`else
                    mode_d = 1'b0 & mode_256;
`endif
                end
            end
            ST_LOAD: begin
                c.init                    = 1'b1;
                c.enable_pipe_low         = 1'b1;
                c.enable_pipe_high        = 1'b1;
                c.rcon_rst                = 1'b1;
                c.rcon_mode_256           = mode_q;
                c.rst_buffer_from_sbox    = 1'b1;
                c.enable_buffer_from_sbox = 1'b1;
                beat_clr                  = 1'b1;
                round_clr                 = 1'b1;
                half_d                    = 1'b0;
                state_d                   = ST_OUT;
            end
            ST_OUT: begin
                c.ak_valid = 1'b1;
                if (ak_ready) begin
                    c.loop               = 1'b1;
                    c.enable_pipe_low    = ~half_q;
                    c.enable_pipe_high   = half_q;
                    c.feedback_from_high = half_q;
                    beat_inc             = 1'b1;
                    if (beat_last) begin
                        if (round == n_upd) begin
                            state_d = ST_DONE;
                        end else if (mode_q && !half_q && (round == '0)) begin
                            half_d = 1'b1;
                        end else begin
                            state_d = ST_ISSUE;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                c.sbox_key_valid   = 1'b1;
                c.disable_rot_rcon = upd_half;
                c.col7_toSB        = mode_q & (round == '0);
                wait_clr           = 1'b1;
                state_d            = (SBOX_LAT > 1) ? ST_WAIT : ST_UPD;
            end
            ST_WAIT: begin
                wait_inc = 1'b1;
                if (wait_last) begin
                    state_d = ST_UPD;
                end
            end
            ST_UPD: begin
                c.enable_pipe_low  = ~upd_half;
                c.enable_pipe_high = upd_half;
                c.disable_rot_rcon = upd_half;
                c.add_from_sb      = (beat == '0);
                beat_inc           = 1'b1;
                if (beat_last) begin
                    c.rcon_update   = ~upd_half;
                    c.rcon_mode_256 = mode_q & ~upd_half;
                    round_inc       = 1'b1;
                    half_d          = upd_half;
                    state_d         = ST_OUT;
                end
            end
            ST_DONE: begin
                c.done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            half_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            half_q  <= half_d;
        end
    end

    // Reset silences every strobe in the same cycle so an aborted schedule leaves no trailing pulse.
    assign c_out = rst ? '0 : c;

    assign key_ready               = c_out.key_ready;
    assign ak_valid                = c_out.ak_valid;
    assign done                    = c_out.done;
    assign init                    = c_out.init;
    assign loop                    = c_out.loop;
    assign add_from_sb             = c_out.add_from_sb;
    assign enable_pipe_low         = c_out.enable_pipe_low;
    assign enable_pipe_high        = c_out.enable_pipe_high;
    assign feedback_from_high      = c_out.feedback_from_high;
    assign disable_rot_rcon        = c_out.disable_rot_rcon;
    assign col7_toSB               = c_out.col7_toSB;
    assign rcon_rst                = c_out.rcon_rst;
    assign rcon_update             = c_out.rcon_update;
    assign rcon_mode_256           = c_out.rcon_mode_256;
    assign enable_buffer_from_sbox = c_out.enable_buffer_from_sbox;
    assign rst_buffer_from_sbox    = c_out.rst_buffer_from_sbox;
    assign sbox_key_valid          = c_out.sbox_key_valid;
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - self-checking bench for aes_key_sched_ctrl against a phase-list model
module tb_aes_key_sched_ctrl;
    localparam int L = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_valid = 1'b0;
    logic mode_256 = 1'b0;
    logic ak_ready = 1'b0;
    logic key_ready, ak_valid, done, init, loop, add_from_sb, enable_pipe_low, enable_pipe_high;
    logic feedback_from_high, disable_rot_rcon, col7_toSB, rcon_rst, rcon_update, rcon_mode_256;
    logic enable_buffer_from_sbox, rst_buffer_from_sbox, sbox_key_valid;

    always #5 clk = ~clk;

    aes_key_sched_ctrl #(.SBOX_LAT(L)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready), .mode_256(mode_256),
        .ak_valid(ak_valid), .ak_ready(ak_ready), .done(done), .init(init), .loop(loop),
        .add_from_sb(add_from_sb), .enable_pipe_low(enable_pipe_low), .enable_pipe_high(enable_pipe_high),
        .feedback_from_high(feedback_from_high), .disable_rot_rcon(disable_rot_rcon), .col7_toSB(col7_toSB),
        .rcon_rst(rcon_rst), .rcon_update(rcon_update), .rcon_mode_256(rcon_mode_256),
        .enable_buffer_from_sbox(enable_buffer_from_sbox), .rst_buffer_from_sbox(rst_buffer_from_sbox),
        .sbox_key_valid(sbox_key_valid)
    );

    localparam int B_RDY = 16, B_AKV = 15, B_DONE = 14, B_INIT = 13, B_LOOP = 12, B_ADD = 11;
    localparam int B_EPL = 10, B_EPH = 9, B_FFH = 8, B_DRR = 7, B_C7 = 6, B_RRST = 5, B_RUPD = 4;
    localparam int B_RM = 3, B_EBUF = 2, B_RBUF = 1, B_SKV = 0;

    wire [16:0] outv = {key_ready, ak_valid, done, init, loop, add_from_sb, enable_pipe_low,
                        enable_pipe_high, feedback_from_high, disable_rot_rcon, col7_toSB, rcon_rst,
                        rcon_update, rcon_mode_256, enable_buffer_from_sbox, rst_buffer_from_sbox,
                        sbox_key_valid};

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        bit          is_out;
        bit          half;
        logic [16:0] vec;
    } item_t;
    item_t q[$];

    int cyc = 0, n_acc = 0, n_done = 0, n_beats = 0, n_low = 0, n_rupd = 0, n_init = 0, n_skv = 0;
    int acc_cyc = 0, done_cyc = 0;
    logic [31:0] drr_log = '0;
    logic [31:0] c7_log = '0;

    function automatic logic [16:0] bm(input int b);
        return 17'd1 << b;
    endfunction

    function automatic bit eff_mode(input bit m);
`ifdef AES256_EN
        return m;
`else
        return 1'b0 & m;
`endif
    endfunction

    function automatic void push_fix(input logic [16:0] v);
        item_t it;
        it.is_out = 1'b0;
        it.half = 1'b0;
        it.vec = v;
        q.push_back(it);
    endfunction

    function automatic void push_out_phase(input bit h);
        item_t it;
        it.is_out = 1'b1;
        it.half = h;
        it.vec = '0;
        for (int i = 0; i < 4; i++) q.push_back(it);
    endfunction

    // Expected schedule as a flat list of cycles: load, out phases and update rounds, then done.
    function automatic void build_key(input bit m);
        int nupd;
        bit hi;
        logic [16:0] v;
        nupd = m ? 13 : 10;
        push_fix(bm(B_INIT) | bm(B_EPL) | bm(B_EPH) | bm(B_RRST) | bm(B_RBUF) | bm(B_EBUF) | (m ? bm(B_RM) : 17'd0));
        push_out_phase(1'b0);
        if (m) push_out_phase(1'b1);
        for (int k = 1; k <= nupd; k++) begin
            hi = m && (k % 2 == 0);
            push_fix(bm(B_SKV) | (hi ? bm(B_DRR) : 17'd0) | ((m && k == 1) ? bm(B_C7) : 17'd0));
            for (int w = 0; w < L - 1; w++) push_fix(17'd0);
            for (int b = 0; b < 4; b++) begin
                v = hi ? (bm(B_EPH) | bm(B_DRR)) : bm(B_EPL);
                if (b == 0) v = v | bm(B_ADD);
                if (b == 3 && !hi) v = v | bm(B_RUPD) | (m ? bm(B_RM) : 17'd0);
                push_fix(v);
            end
            push_out_phase(hi);
        end
        push_fix(bm(B_DONE));
    endfunction

    always @(negedge clk) begin
        logic [16:0] exp_v;
        item_t it;
        cyc++;
        if (rst) begin
            exp_v = '0;
            q.delete();
        end else if (q.size() == 0) begin
            exp_v = bm(B_RDY);
            if (key_valid) begin
                build_key(eff_mode(mode_256));
                n_acc++;
                acc_cyc = cyc;
            end
        end else begin
            it = q[0];
            if (it.is_out) begin
                exp_v = bm(B_AKV);
                if (ak_ready) begin
                    exp_v = exp_v | bm(B_LOOP) | (it.half ? (bm(B_EPH) | bm(B_FFH)) : bm(B_EPL));
                    void'(q.pop_front());
                end
            end else begin
                exp_v = it.vec;
                void'(q.pop_front());
            end
        end
        n_checks++;
        if (outv !== exp_v) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL cycle_outputs cyc=%0d got=%b want=%b", cyc, outv, exp_v);
        end
        if (!rst) begin
            if (ak_valid && ak_ready) n_beats++;
            if (ak_valid && !ak_ready) n_low++;
            if (rcon_update) n_rupd++;
            if (init) n_init++;
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (sbox_key_valid) begin
                n_skv++;
                drr_log = {drr_log[30:0], disable_rot_rcon};
                c7_log = {c7_log[30:0], col7_toSB};
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // rpat: 0 ready always, 1 alternating, 2 random
    task automatic run_key(input bit m, input int rpat, input bit hold,
                           output int beats, output int rupd, output int lat, output int low);
        int b_acc, b_done, b_beats, b_low, b_rupd, b_init, to, em, nupd;
        b_acc = n_acc; b_done = n_done; b_beats = n_beats; b_low = n_low; b_rupd = n_rupd; b_init = n_init;
        @(posedge clk); #1;
        key_valid = 1'b1;
        mode_256 = m;
        ak_ready = 1'b1;
        to = 0;
        while (n_acc == b_acc && to < 50) begin
            @(negedge clk);
            to++;
        end
        @(posedge clk); #1;
        if (!hold) key_valid = 1'b0;
        to = 0;
        while (n_done == b_done && to < 3000) begin
            @(posedge clk); #1;
            if (hold && done) key_valid = 1'b0;
            case (rpat)
                0: ak_ready = 1'b1;
                1: ak_ready = (to % 2 == 0);
                default: ak_ready = ($urandom_range(0, 3) != 0);
            endcase
            to++;
        end
        key_valid = 1'b0;
        @(negedge clk);
        check("ready_after_done", int'(key_ready), 1);
        beats = n_beats - b_beats;
        rupd = n_rupd - b_rupd;
        low = n_low - b_low;
        lat = done_cyc - acc_cyc - 1;
        em = int'(eff_mode(m));
        nupd = (em != 0) ? 13 : 10;
        check("done_count", n_done - b_done, 1);
        check("accept_count", n_acc - b_acc, 1);
        check("init_count", n_init - b_init, 1);
        check("beats_model", beats, (em != 0) ? 60 : 44);
        check("rcon_update_model", rupd, (em != 0) ? 7 : 10);
        check("latency_model", lat, 1 + 4 * (1 + em) + nupd * (L + 8) + low);
    endtask

    initial begin
        int beats, rupd, lat, low, b_skv, b_done, to;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs_zero", int'(outv), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", int'(key_ready), 1);

        run_key(1'b0, 0, 1'b0, beats, rupd, lat, low);
        check("aes128_beats", beats, 44);
        check("aes128_rcon_updates", rupd, 10);
        check("aes128_latency", lat, 125);

        run_key(1'b0, 1, 1'b0, beats, rupd, lat, low);
        check("alt_ready_beats", beats, 44);
        check("alt_ready_low_seen", int'(low > 0), 1);

        run_key(1'b0, 0, 1'b1, beats, rupd, lat, low);
        check("hold_valid_latency", lat, 125);

        b_skv = n_skv;
        b_done = n_done;
        @(posedge clk); #1;
        key_valid = 1'b1;
        mode_256 = 1'b0;
        ak_ready = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        to = 0;
        while (n_skv - b_skv < 5 && to < 2000) begin
            @(negedge clk);
            to++;
        end
        check("reached_round5_issue", n_skv - b_skv, 5);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrun_reset_zero", int'(outv), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_midrun_reset", int'(key_ready), 1);
        repeat (20) @(negedge clk);
        check("no_done_after_abort", n_done - b_done, 0);
        run_key(1'b0, 0, 1'b0, beats, rupd, lat, low);
        check("post_reset_beats", beats, 44);

`ifdef AES256_EN
        run_key(1'b1, 0, 1'b0, beats, rupd, lat, low);
        check("aes256_beats", beats, 60);
        check("aes256_rcon_updates", rupd, 7);
        check("aes256_latency", lat, 165);
        check("aes256_drr_pattern", int'(drr_log[12:0]), int'(13'b0101010101010));
        check("aes256_col7_pattern", int'(c7_log[12:0]), int'(13'b1000000000000));
`else
        run_key(1'b1, 0, 1'b0, beats, rupd, lat, low);
        check("mode256_ignored_beats", beats, 44);
        check("mode256_ignored_latency", lat, 125);
`endif

        for (int i = 0; i < 8; i++) begin
            run_key(1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)), beats, rupd, lat, low);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
